seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.

---
 rtl/seg_scan_ctrl_pkg.sv | 26 ++
 rtl/seg_scan_ctrl_bcd_to_7.sv | 33 +++
 rtl/seg_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_pkg
//   Shared definitions for the 7-segment scan controller: scan FSM state
//   encoding and the segment glyph constants (bit 0 = segment a ... bit 6 = g,
//   active-high).
// -----------------------------------------------------------------------------
package seg_scan_ctrl_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_scan_ctrl_bcd_to_7.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_bcd_to_7
//   Combinational BCD to 7-segment decoder. Non-BCD codes (10..15) are shown
//   as a dark digit.
//   Ports:
//     num  in  4  BCD digit
//     seg  out 7  segments a..g, active-high, seg[0] = a
// -----------------------------------------------------------------------------
module seg_scan_ctrl_bcd_to_7
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] num,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (num)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for an N-digit common-anode 7-segment
//   display. Each digit slot lasts REFRESH_DIV cycles: BLANK_CYC cycles with all
//   anodes off (anti-ghosting), then the digit is driven. New values are staged
//   in a pending buffer and only moved to the display buffer at the frame wrap,
//   so a frame is never torn.
//   Ports:
//     clk         in   1           system clock (rising edge)
//     rst         in   1           synchronous active-high reset
//     en          in   1           scan enable, 0 = display dark
//     load        in   1           strobe: capture digits/dp_in into pending
//     digits      in   4*N_DIGITS  BCD digits, [3:0] = digit 0 (rightmost)
//     dp_in       in   N_DIGITS    decimal point request per digit
//     lz_supp     in   1           blank leading zeros (digit 0 never blanked)
//     an          out  N_DIGITS    anode select, active-low
//     seg         out  7           segments a..g, active-high
//     dp          out  1           decimal point, active-high
//     frame_done  out  1           1-cycle pulse when the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_supp,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic                    wrap;

  logic [4*N_DIGITS-1:0]   disp_dig_reg, pend_dig_reg;
  logic [N_DIGITS-1:0]     disp_dp_reg, pend_dp_reg;
  logic                    pend_flag_reg;

  logic [N_DIGITS-1:0]     an_reg, an_next;
  logic [6:0]              seg_reg, seg_next;
  logic                    dp_reg, dp_next;
  logic                    fd_reg;

  logic [3:0]              disp_arr [N_DIGITS];
  logic [N_DIGITS-1:0]     zero_flags;
  logic [N_DIGITS-1:0]     lz_blank;
  logic [6:0]              dec_seg;

  // Digit k is a leading zero when it and every more significant digit are 0.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign disp_arr[gi]   = disp_dig_reg[4*gi +: 4];
    assign zero_flags[gi] = (disp_arr[gi] == 4'd0);
    if (gi == 0) begin : g_lsd
      assign lz_blank[gi] = 1'b0;
    end else begin : g_upper
      assign lz_blank[gi] = &zero_flags[N_DIGITS-1:gi];
    end
  end

  // Decoder looks at the digit about to be shown so the registered outputs
  // line up with the state/idx registers.
  seg_scan_ctrl_bcd_to_7 u_dec (
    .num (disp_arr[idx_next]),
    .seg (dec_seg)
  );

  // Next-state: slot counter, digit index and BLANK/SHOW phase.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    wrap       = 1'b0;
    if (!en) begin
      state_next = ST_BLANK;
      cnt_next   = '0;
      idx_next   = '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next   = '0;
      state_next = ST_BLANK;
      if (idx_reg == IDX_LAST) begin
        idx_next = '0;
        wrap     = 1'b1;
      end else begin
        idx_next = idx_reg + 1'b1;
      end
    end else begin
      cnt_next = cnt_reg + 1'b1;
      case (state_reg)
        ST_BLANK: if (cnt_reg == BLANK_END) state_next = ST_SHOW;
        ST_SHOW:  state_next = ST_SHOW;
        default:  state_next = ST_BLANK;
      endcase
    end
  end

  // Output values for the next cycle; everything is dark outside SHOW.
  always_comb begin
    an_next  = '1;
    seg_next = SEG_BLANK;
    dp_next  = 1'b0;
    if (state_next == ST_SHOW) begin
      an_next[idx_next] = 1'b0;
      seg_next = (lz_supp && lz_blank[idx_next]) ? SEG_BLANK : dec_seg;
      dp_next  = disp_dp_reg[idx_next];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_BLANK;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      disp_dig_reg  <= '0;
      disp_dp_reg   <= '0;
      pend_dig_reg  <= '0;
      pend_dp_reg   <= '0;
      pend_flag_reg <= 1'b0;
      an_reg        <= '1;
      seg_reg       <= SEG_BLANK;
      dp_reg        <= 1'b0;
      fd_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      an_reg    <= an_next;
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      fd_reg    <= wrap;
      // Transfer uses the old pending contents; a load in the same cycle
      // re-arms the flag (the later assignment wins) for the next wrap.
      if (wrap && pend_flag_reg) begin
        disp_dig_reg  <= pend_dig_reg;
        disp_dp_reg   <= pend_dp_reg;
        pend_flag_reg <= 1'b0;
      end
      if (load) begin
        pend_dig_reg  <= digits;
        pend_dp_reg   <= dp_in;
        pend_flag_reg <= 1'b1;
      end
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign frame_done = fd_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Self-checking bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank
//   cycles). A reference model tracks the position inside the frame as a plain
//   cycle number and derives digit/phase arithmetically; all outputs are
//   compared every cycle.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;
  localparam int FRAME = N * R;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   digits = '0;
  logic [3:0]    dp_in = '0;
  logic          lz_supp = 1'b0;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  // model state
  int          p = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0]  m_disp_dp = '0, m_pend_dp = '0;
  bit          m_flag = 1'b0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = '0;
  logic        e_dp = 1'b0;
  logic        e_fd = 1'b0;

  logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYC(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .digits     (digits),
    .dp_in      (dp_in),
    .lz_supp    (lz_supp),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(int v);
    return (v <= 9) ? glyph_tab[v] : 7'h00;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at t=%0t p=%0d", tag, obs, exp, $time, p);
    end
  endtask

  // One clock: advance the model using the inputs seen at the edge, then
  // compare every output 1 time unit later.
  task automatic tick();
    bit wrap;
    int k;
    int upper;
    @(posedge clk);
    if (rst) begin
      p = 0; m_disp = '0; m_disp_dp = '0; m_pend = '0; m_pend_dp = '0; m_flag = 1'b0;
      e_an = 4'hF; e_seg = '0; e_dp = 1'b0; e_fd = 1'b0;
    end else begin
      wrap = en && (p == FRAME - 1);
      if (wrap && m_flag) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp; m_flag = 1'b0;
      end
      if (load) begin
        m_pend = digits; m_pend_dp = dp_in; m_flag = 1'b1;
      end
      p = en ? (p + 1) % FRAME : 0;
      e_fd = wrap;
      k = p / R;
      if (en && (p % R) >= B) begin
        upper = int'(m_disp >> (4 * k));
        e_an  = 4'hF & ~(4'b0001 << k);
        e_seg = (lz_supp && k > 0 && upper == 0) ? 7'h00 : glyph(upper % 16);
        e_dp  = m_disp_dp[k];
      end else begin
        e_an = 4'hF; e_seg = '0; e_dp = 1'b0;
      end
    end
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the next edge is taken at frame position 'target'.
  task automatic wait_p(int target);
    int n = 0;
    while (p != target && n < 4 * FRAME) begin
      tick();
      n++;
    end
    if (p != target) begin
      errors++;
      $display("FAIL wait_p: position=%0d required=%0d", p, target);
    end
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] pd);
    digits = d;
    dp_in  = pd;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    $display("load digits=%h dp=%b lz=%0d en=%0d pos=%0d", d, pd, lz_supp, en, p);
  endtask

  initial begin
    int fd_count;
    // reset state
    rst = 1'b1;
    run(2);
    $display("reset checked");

    // 1: load 1234, scan two frames
    rst = 1'b0;
    en  = 1'b1;
    do_load(16'h1234, 4'b0000);
    run(2 * FRAME);
    fd_count = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (frame_done) fd_count++;
    end
    chk("frame_done_count", 32'(fd_count), 32'd2);

    // 2: two loads in one frame, last wins
    wait_p(10);
    do_load(16'h5678, 4'b0000);
    wait_p(20);
    do_load(16'h9999, 4'b0000);
    run(2 * FRAME);

    // load coincident with wrap
    wait_p(20);
    do_load(16'h8765, 4'b1000);
    wait_p(FRAME - 1);
    do_load(16'h4321, 4'b0001);
    run(2 * FRAME);

    // 3: leading-zero suppression
    lz_supp = 1'b1;
    wait_p(5);
    do_load(16'h0050, 4'b0000);
    run(2 * FRAME);
    do_load(16'h0000, 4'b0000);
    run(2 * FRAME);

    // 4: non-BCD digit with decimal point
    lz_supp = 1'b0;
    do_load(16'h00A0, 4'b0010);
    run(2 * FRAME);

    // 5: enable dropped in digit 2 SHOW, then restored
    wait_p(2 * R + 4);
    en = 1'b0;
    tick();
    chk("en_off_an", 32'(an), 32'hF);
    run(3);
    en = 1'b1;
    run(FRAME + 4);
    $display("enable drop/restore done");

    // 6: reset mid-slot discards the pending load
    wait_p(R + 5);
    do_load(16'h7777, 4'b1111);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(2 * FRAME);
    $display("reset mid-slot done");

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] d;
      for (int j = 0; j < 4; j++)
        d[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      digits  = d;
      dp_in   = 4'($urandom_range(0, 15));
      load    = ($urandom_range(0, 20) == 0);
      en      = ($urandom_range(0, 60) != 0);
      rst     = ($urandom_range(0, 500) == 0);
      if ($urandom_range(0, 100) == 0) lz_supp = ~lz_supp;
      if (load) $display("rand load digits=%h dp=%b lz=%0d en=%0d pos=%0d", d, dp_in, lz_supp, en, p);
      tick();
    end
    load = 1'b0;
    rst  = 1'b0;
    en   = 1'b1;
    run(FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
